mem_lsu: RTL

- Load/store unit directly upstream of the byte-enabled program/data block RAM.
  - That RAM is word-addressed via addr[31:2], uses per-byte write enables, and has 1-cycle synchronous read.
- Converts core requests (funct3, byte address, store data) into RAM word accesses.
  - Stores: builds byte enables and shifts write data.
  - Loads: extracts, aligns and sign/zero-extends the returned data.
- Accesses that cross a word boundary are split into two RAM transactions.

---
 rtl/mem_lsu_pkg.sv | 35 +++
 rtl/mem_lsu_if.sv | 25 ++
 rtl/mem_lsu_align.sv | 37 +++
 rtl/mem_lsu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings,
// FSM state encoding and access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        LD_LO,
        LD_HI,
        ST_HI
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Core-side request/response channel of the load/store unit.
interface mem_lsu_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [2:0]               req_funct3;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane datapath: store mask and data placement across a two-word
// window, and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata64,
    output logic [7:0]  mask8,
    output logic [63:0] data64,
    output logic [31:0] load_val
);
    logic [7:0]  base_mask;
    logic [63:0] shifted;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        case (size_bytes(funct3))
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        mask8   = base_mask << off;
        data64  = {32'b0, wdata} << {off, 3'b000};
        shifted = rdata64 >> {off, 3'b000};

        load_val = shifted[31:0];
        case (funct3)
            F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_val = {24'b0, shifted[7:0]};
            F3_HU:   load_val = {16'b0, shifted[15:0]};
            default: load_val = shifted[31:0];
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a byte-enabled, 1-cycle synchronous-read RAM.
// Word-crossing accesses become two RAM transactions (or are rejected).
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_lsu_if.slave                 bus,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [3:0]               ram_be,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);
    lsu_state_t state;

    logic [2:0]               funct3_q;
    logic [1:0]               off_q;
    logic                     split_q;
    logic [ADDRESS_WIDTH-1:0] addr_hi_q;
    logic [3:0]               be_hi_q;
    logic [31:0]              wdata_hi_q;
    logic [31:0]              lo_q;

    logic                     rsp_valid_q;
    logic [31:0]              rsp_rdata_q;
    logic                     rsp_err_q;

    logic [1:0]               req_off;
    logic [2:0]               req_n;
    logic                     req_split;
    logic                     req_reject;
    logic                     accept;
    logic                     store_write;
    logic [ADDRESS_WIDTH-3:0] req_word_nxt;

    logic [2:0]               al_funct3;
    logic [1:0]               al_off;
    logic [63:0]              al_rdata64;
    logic [7:0]               mask8;
    logic [63:0]              data64;
    logic [31:0]              load_val;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign req_off      = bus.req_addr[1:0];
    assign req_n        = size_bytes(bus.req_funct3);
    assign req_split    = ({2'b00, req_off} + {1'b0, req_n}) > 4'd4;
    assign req_reject   = !funct3_legal(bus.req_funct3, bus.req_we)
                       || (req_split && (MISALIGN_SPLIT == 0));
    assign accept       = bus.req_valid && bus.req_ready;
    assign store_write  = bus.req_valid && bus.req_we && !req_reject;
    assign req_word_nxt = bus.req_addr[ADDRESS_WIDTH-1:2] + (ADDRESS_WIDTH-2)'(1);

    // One aligner serves both directions: stores only use it while IDLE,
    // loads only after leaving IDLE.
    assign al_funct3  = (state == IDLE) ? bus.req_funct3 : funct3_q;
    assign al_off     = (state == IDLE) ? req_off : off_q;
    assign al_rdata64 = (state == LD_HI) ? {ram_rdata, lo_q} : {32'b0, ram_rdata};

    lsu_align u_align (
        .funct3   (al_funct3),
        .off      (al_off),
        .wdata    (bus.req_wdata),
        .rdata64  (al_rdata64),
        .mask8    (mask8),
        .data64   (data64),
        .load_val (load_val)
    );

    // RAM is driven straight from the request in IDLE so it samples on the accept edge.
    always_comb begin
        ram_addr  = addr_hi_q;
        ram_be    = 4'b0000;
        ram_wdata = wdata_hi_q;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                ram_addr  = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                ram_wdata = data64[31:0];
                if (store_write) begin
                    ram_be = mask8[3:0];
                    ram_we = 1'b1;
                end
            end
            ST_HI: begin
                ram_be = be_hi_q;
                ram_we = 1'b1;
            end
            default: ;
        endcase
        if (rst) ram_we = 1'b0;
    end

    // NOTE: request latches carry no reset; they are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            funct3_q   <= bus.req_funct3;
            off_q      <= req_off;
            split_q    <= req_split;
            addr_hi_q  <= {req_word_nxt, 2'b00};
            be_hi_q    <= mask8[7:4];
            wdata_hi_q <= data64[63:32];
        end
        if (state == LD_LO) lo_q <= ram_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_reject) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (bus.req_we) begin
                            if (req_split) state <= ST_HI;
                            else           rsp_valid_q <= 1'b1;
                        end else begin
                            state <= LD_LO;
                        end
                    end
                end
                LD_LO: begin
                    if (split_q) begin
                        state <= LD_HI;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_val;
                        state       <= IDLE;
                    end
                end
                LD_HI: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_val;
                    state       <= IDLE;
                end
                ST_HI: begin
                    rsp_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
